// File: rtl/sin_phase_det.sv
// sin_phase_det: locks a local phase counter to an incoming 16-point sine
// stream by finding its unique peak, then checks every later sample against
// the same table and reports lock, phase and sample errors.
module sin_phase_det #(
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid,
  input  logic        clear_err,
  output logic        locked,
  output logic [3:0]  phase,
  output logic        phase_valid,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // Index 0 sits in the least significant byte.
  localparam logic [127:0] TABLE_PACKED = {
    8'd62, 8'd29, 8'd8, 8'd0, 8'd8, 8'd29, 8'd62, 8'd100,
    8'd138, 8'd171, 8'd192, 8'd200, 8'd192, 8'd171, 8'd138, 8'd100
  };
  localparam logic [7:0] PEAK_VAL = 8'd200;
  localparam logic [3:0] PEAK_IDX_NEXT = 4'd5;

  state_t      state_reg;
  logic [3:0]  pred_reg;
  logic [7:0]  match_cnt_reg;
  logic [3:0]  miss_cnt_reg;

  logic [7:0]  table_val [16];
  logic [7:0]  expected;
  logic signed [8:0] diff_pred;
  logic signed [8:0] diff_peak;
  logic [8:0]  mag_pred;
  logic [8:0]  mag_peak;
  logic        sample_match;
  logic        peak_match;
  logic        err_hit;
  logic [7:0]  match_cnt_inc;
  logic [3:0]  miss_cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_table
      assign table_val[gi] = TABLE_PACKED[gi*8 +: 8];
    end
  endgenerate

  // Magnitude comparisons against the predicted entry and against the peak.
  always_comb begin
    expected     = table_val[pred_reg];
    diff_pred    = $signed({1'b0, sample_in}) - $signed({1'b0, expected});
    diff_peak    = $signed({1'b0, sample_in}) - $signed({1'b0, PEAK_VAL});
    mag_pred     = diff_pred[8] ? 9'(-diff_pred) : 9'(diff_pred);
    mag_peak     = diff_peak[8] ? 9'(-diff_peak) : 9'(diff_peak);
    sample_match = (mag_pred <= 9'(TOL));
    peak_match   = (mag_peak <= 9'(TOL));
    err_hit      = sample_valid && (state_reg == LOCKED) && !sample_match;
    match_cnt_inc = match_cnt_reg + 8'd1;
    miss_cnt_inc  = miss_cnt_reg + 4'd1;
  end

  assign phase_valid = locked;

  // Search / verify / locked sequencing with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SEARCH;
      pred_reg      <= 4'd0;
      match_cnt_reg <= 8'd0;
      miss_cnt_reg  <= 4'd0;
      locked        <= 1'b0;
      phase         <= 4'd0;
    end else if (sample_valid) begin
      case (state_reg)
        SEARCH: begin
          if (peak_match) begin
            pred_reg      <= PEAK_IDX_NEXT;
            match_cnt_reg <= 8'd0;
            state_reg     <= VERIFY;
          end
        end
        VERIFY: begin
          if (sample_match) begin
            match_cnt_reg <= match_cnt_inc;
            pred_reg      <= pred_reg + 4'd1;
            if (match_cnt_inc == 8'(LOCK_CNT)) begin
              // The sample completing the run becomes the first reported phase.
              state_reg    <= LOCKED;
              locked       <= 1'b1;
              phase        <= pred_reg;
              miss_cnt_reg <= 4'd0;
            end
          end else begin
            // The failing sample is dropped, not re-checked as a peak.
            state_reg <= SEARCH;
          end
        end
        LOCKED: begin
          phase    <= pred_reg;
          pred_reg <= pred_reg + 4'd1;
          if (sample_match) begin
            miss_cnt_reg <= 4'd0;
          end else begin
            miss_cnt_reg <= miss_cnt_inc;
            if (miss_cnt_inc == 4'(UNLOCK_CNT)) begin
              state_reg <= SEARCH;
              locked    <= 1'b0;
            end
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

  // Error pulse and saturating error counter; clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= 16'd0;
    end else begin
      err_pulse <= err_hit;
      if (clear_err) begin
        err_count <= 16'd0;
      end else if (err_hit && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sin_phase_det.sv
// Directed bench for sin_phase_det: lock timing, tolerance, errors, unlock,
// gapped input, verify failure, counter saturation/clear and async reset.
module tb_sin_phase_det;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sample_in = 8'd0;
  logic        sample_valid = 1'b0;
  logic        clear_err = 1'b0;

  logic        locked, phase_valid, err_pulse;
  logic [3:0]  phase;
  logic [15:0] err_count;

  logic        locked2, phase_valid2, err_pulse2;
  logic [3:0]  phase2;
  logic [15:0] err_count2;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] tbl [16] = '{8'd100, 8'd138, 8'd171, 8'd192, 8'd200, 8'd192, 8'd171, 8'd138,
                           8'd100, 8'd62, 8'd29, 8'd8, 8'd0, 8'd8, 8'd29, 8'd62};

  always #5 clk = ~clk;

  sin_phase_det dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear_err(clear_err), .locked(locked), .phase(phase), .phase_valid(phase_valid),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  // Second instance: fast lock and tolerant unlock, used for saturation.
  sin_phase_det #(.TOL(2), .LOCK_CNT(1), .UNLOCK_CNT(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear_err(clear_err), .locked(locked2), .phase(phase2), .phase_valid(phase_valid2),
    .err_pulse(err_pulse2), .err_count(err_count2)
  );

  function automatic logic [7:0] ideal(input int k);
    return tbl[k % 16];
  endfunction

  task automatic step(input logic [7:0] s, input logic v, input logic c);
    sample_in    = s;
    sample_valid = v;
    clear_err    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    sample_valid = 1'b0;
    clear_err    = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got %0h expected 0", locked); end
    tests_run++; if (phase_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_phase_valid got %0h expected 0", phase_valid); end
    tests_run++; if (phase !== 4'd0) begin tests_failed++; $display("FAIL reset_phase got %0h expected 0", phase); end
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_err_pulse got %0h expected 0", err_pulse); end
    tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL reset_err_count got %0h expected 0", err_count); end
    $display("[TB] test_reset done");
  endtask

  // Continuous stream from index 0 with a constant offset on every sample.
  task automatic test_lock(input int off, input logic expect_lock);
    reset_dut();
    for (int k = 0; k <= 40; k++) begin
      step(8'(int'(ideal(k)) + off), 1'b1, 1'b0);
      if (k == 19) begin
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early off=%0d got %0h expected 0", off, locked); end
      end
      if (k >= 20) begin
        tests_run++; if (locked !== expect_lock) begin tests_failed++; $display("FAIL lock_state off=%0d k=%0d got %0h expected %0h", off, k, locked, expect_lock); end
        tests_run++; if (phase_valid !== expect_lock) begin tests_failed++; $display("FAIL lock_phase_valid off=%0d k=%0d got %0h expected %0h", off, k, phase_valid, expect_lock); end
        if (expect_lock) begin
          tests_run++; if (phase !== 4'(k % 16)) begin tests_failed++; $display("FAIL lock_phase off=%0d k=%0d got %0d expected %0d", off, k, phase, k % 16); end
        end
      end
    end
    tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL lock_err_count off=%0d got %0d expected 0", off, err_count); end
    $display("[TB] test_lock off=%0d locked=%0h phase=%0d", off, locked, phase);
  endtask

  task automatic test_errors();
    reset_dut();
    for (int k = 0; k <= 35; k++) step(ideal(k), 1'b1, 1'b0);
    step(8'd0, 1'b1, 1'b0);  // k=36 expects 200
    tests_run++; if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL err_single_pulse got %0h expected 1", err_pulse); end
    tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("FAIL err_single_count got %0d expected 1", err_count); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL err_single_locked got %0h expected 1", locked); end
    step(ideal(37), 1'b1, 1'b0);
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL err_pulse_width got %0h expected 0", err_pulse); end
    for (int k = 38; k <= 41; k++) begin
      step((k == 41) ? 8'd200 : 8'd255, 1'b1, 1'b0);
      tests_run++; if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL err_burst_pulse k=%0d got %0h expected 1", k, err_pulse); end
      tests_run++; if (err_count !== 16'(k - 36)) begin tests_failed++; $display("FAIL err_burst_count k=%0d got %0d expected %0d", k, err_count, k - 36); end
      tests_run++; if (locked !== (k < 41)) begin tests_failed++; $display("FAIL err_burst_locked k=%0d got %0h expected %0h", k, locked, k < 41); end
    end
    step(ideal(42), 1'b1, 1'b0);
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL err_after_unlock_pulse got %0h expected 0", err_pulse); end
    tests_run++; if (phase_valid !== 1'b0) begin tests_failed++; $display("FAIL err_after_unlock_pv got %0h expected 0", phase_valid); end
    $display("[TB] test_errors err_count=%0d locked=%0h", err_count, locked);
  endtask

  // Alternate valid/invalid cycles; invalid cycles carry a peak value.
  task automatic test_valid_toggle();
    reset_dut();
    for (int k = 0; k <= 21; k++) begin
      step(ideal(k), 1'b1, 1'b0);
      if (k == 20) begin
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL gap_lock got %0h expected 1", locked); end
        tests_run++; if (phase !== 4'd4) begin tests_failed++; $display("FAIL gap_phase got %0d expected 4", phase); end
      end
      if (k == 21) begin
        tests_run++; if (phase !== 4'd5) begin tests_failed++; $display("FAIL gap_phase_next got %0d expected 5", phase); end
      end
      step(8'd200, 1'b0, 1'b0);
      if (k == 19) begin
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL gap_early got %0h expected 0", locked); end
      end
      if (k == 20) begin
        tests_run++; if (phase !== 4'd4) begin tests_failed++; $display("FAIL gap_phase_hold got %0d expected 4", phase); end
      end
    end
    $display("[TB] test_valid_toggle phase=%0d locked=%0h", phase, locked);
  endtask

  // Corrupt the 10th post-peak sample; relock needs the next peak plus 16.
  task automatic test_verify_fail();
    reset_dut();
    for (int k = 0; k <= 36; k++) begin
      step((k == 14) ? 8'd255 : ideal(k), 1'b1, 1'b0);
      if (k == 20 || k == 35) begin
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL vfail_early k=%0d got %0h expected 0", k, locked); end
      end
    end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL vfail_relock got %0h expected 1", locked); end
    tests_run++; if (phase !== 4'd4) begin tests_failed++; $display("FAIL vfail_phase got %0d expected 4", phase); end
    tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL vfail_err_count got %0d expected 0", err_count); end
    $display("[TB] test_verify_fail locked=%0h phase=%0d", locked, phase);
  endtask

  task automatic test_saturation();
    int k, errs, miss;
    reset_dut();
    for (k = 0; k <= 5; k++) step(ideal(k), 1'b1, 1'b0);
    tests_run++; if (locked2 !== 1'b1) begin tests_failed++; $display("FAIL sat_lock got %0h expected 1", locked2); end
    errs = 0;
    miss = 0;
    while (errs < 65535) begin
      if (miss == 14) begin
        step(ideal(k), 1'b1, 1'b0);
        miss = 0;
      end else begin
        step(8'd255, 1'b1, 1'b0);
        errs++;
        miss++;
      end
      k++;
    end
    step(ideal(k), 1'b1, 1'b0);
    k++;
    tests_run++; if (err_count2 !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_full got %0h expected ffff", err_count2); end
    step(8'd255, 1'b1, 1'b0);
    k++;
    tests_run++; if (err_count2 !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold got %0h expected ffff", err_count2); end
    tests_run++; if (err_pulse2 !== 1'b1) begin tests_failed++; $display("FAIL sat_pulse got %0h expected 1", err_pulse2); end
    step(8'd255, 1'b1, 1'b1);
    tests_run++; if (err_count2 !== 16'd0) begin tests_failed++; $display("FAIL sat_clear got %0h expected 0", err_count2); end
    tests_run++; if (locked2 !== 1'b1) begin tests_failed++; $display("FAIL sat_locked got %0h expected 1", locked2); end
    clear_err = 1'b0;
    $display("[TB] test_saturation err_count=%0h", err_count2);
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int k = 0; k <= 20; k++) step(ideal(k), 1'b1, 1'b0);
    step(8'd255, 1'b1, 1'b0);
    tests_run++; if (err_count !== 16'd1) begin tests_failed++; $display("FAIL arst_pre_count got %0d expected 1", err_count); end
    sample_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL arst_locked got %0h expected 0", locked); end
    tests_run++; if (phase_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_phase_valid got %0h expected 0", phase_valid); end
    tests_run++; if (phase !== 4'd0) begin tests_failed++; $display("FAIL arst_phase got %0d expected 0", phase); end
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL arst_err_pulse got %0h expected 0", err_pulse); end
    tests_run++; if (err_count !== 16'd0) begin tests_failed++; $display("FAIL arst_err_count got %0d expected 0", err_count); end
    rst_n = 1'b1;
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_lock(0, 1'b1);
    test_lock(2, 1'b1);
    test_lock(3, 1'b0);
    test_errors();
    test_valid_toggle();
    test_verify_fail();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
